// File: rtl/cordic_circ_rot_mode.sv
// Sequential circular CORDIC in rotation mode: rotates (x_i, y_i) by theta_i,
// one micro-rotation per clock, then one gain-compensation step with saturation.
module cordic_circ_rot_mode #(
  parameter int IO_WIDTH    = 18,
  parameter int ITER_NUM    = 16,
  parameter int SCALE_CONS  = 622,
  parameter int SCALE_SHIFT = 10
) (
  input  logic                sys_clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [IO_WIDTH-1:0] x_i,
  input  logic [IO_WIDTH-1:0] y_i,
  input  logic [IO_WIDTH-1:0] theta_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [IO_WIDTH-1:0] x_o,
  output logic [IO_WIDTH-1:0] y_o,
  output logic [1:0]          state_o
);
  // Handshake: start_i is accepted on an edge where the engine is IDLE; done_o
  // then pulses for one cycle exactly ITER_NUM+1 edges later with x_o/y_o valid.
  localparam int XW = IO_WIDTH + 2;
  localparam int ZW = IO_WIDTH + 1;
  localparam int PW = XW + 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROT   = 2'd1;
  localparam logic [1:0] S_SCALE = 2'd2;

  localparam logic [4:0]           LAST_ITER = 5'(ITER_NUM - 1);
  localparam logic signed [ZW-1:0] QUARTER   = ZW'(2 ** (IO_WIDTH - 2));
  localparam logic signed [PW-1:0] SAT_MAX   = PW'((2 ** (IO_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_MIN   = ~SAT_MAX;
  localparam logic signed [PW-1:0] SCALE_K   = PW'(SCALE_CONS);

  logic [1:0]           state;
  logic [4:0]           iter;
  logic signed [XW-1:0] x_r, y_r;
  logic signed [ZW-1:0] z_r;

  logic signed [XW-1:0] x_ext, y_ext, x_init, y_init;
  logic signed [ZW-1:0] theta_ext, z_init;
  logic signed [XW-1:0] x_sh, y_sh, x_nx, y_nx;
  logic signed [ZW-1:0] atan_v, z_nx;
  logic signed [PW-1:0] x_prod, y_prod, x_scl, y_scl;

  function automatic logic signed [ZW-1:0] atan_lut(input logic [3:0] i);
    logic signed [ZW-1:0] v;
    case (i)
      4'd0:    v = ZW'(32768);
      4'd1:    v = ZW'(19344);
      4'd2:    v = ZW'(10221);
      4'd3:    v = ZW'(5188);
      4'd4:    v = ZW'(2604);
      4'd5:    v = ZW'(1303);
      4'd6:    v = ZW'(652);
      4'd7:    v = ZW'(326);
      4'd8:    v = ZW'(163);
      4'd9:    v = ZW'(81);
      4'd10:   v = ZW'(41);
      4'd11:   v = ZW'(20);
      4'd12:   v = ZW'(10);
      4'd13:   v = ZW'(5);
      4'd14:   v = ZW'(3);
      default: v = ZW'(1);
    endcase
    return v;
  endfunction

  function automatic logic [IO_WIDTH-1:0] sat(input logic signed [PW-1:0] v);
    logic [IO_WIDTH-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX[IO_WIDTH-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[IO_WIDTH-1:0];
    else                  r = v[IO_WIDTH-1:0];
    return r;
  endfunction

  assign x_ext     = {{2{x_i[IO_WIDTH-1]}}, x_i};
  assign y_ext     = {{2{y_i[IO_WIDTH-1]}}, y_i};
  assign theta_ext = {theta_i[IO_WIDTH-1], theta_i};

  // Quadrant pre-rotation by +/-90 deg keeps the residual angle inside the
  // convergence range of the micro-rotations.
  always_comb begin
    x_init = x_ext;
    y_init = y_ext;
    z_init = theta_ext;
    if (theta_ext > QUARTER) begin
      x_init = -y_ext;
      y_init = x_ext;
      z_init = theta_ext - QUARTER;
    end else if (theta_ext < -QUARTER) begin
      x_init = y_ext;
      y_init = -x_ext;
      z_init = theta_ext + QUARTER;
    end
  end

  always_comb begin
    x_sh   = x_r >>> iter;
    y_sh   = y_r >>> iter;
    atan_v = atan_lut(iter[3:0]);
    if (!z_r[ZW-1]) begin
      x_nx = x_r - y_sh;
      y_nx = y_r + x_sh;
      z_nx = z_r - atan_v;
    end else begin
      x_nx = x_r + y_sh;
      y_nx = y_r - x_sh;
      z_nx = z_r + atan_v;
    end
  end

  assign x_prod = PW'(x_r) * SCALE_K;
  assign y_prod = PW'(y_r) * SCALE_K;
  assign x_scl  = x_prod >>> SCALE_SHIFT;
  assign y_scl  = y_prod >>> SCALE_SHIFT;

  always_ff @(posedge sys_clk_i) begin
    if (reset_i) begin
      state  <= S_IDLE;
      iter   <= '0;
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
      x_o    <= '0;
      y_o    <= '0;
      done_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            x_r    <= x_init;
            y_r    <= y_init;
            z_r    <= z_init;
            iter   <= '0;
            busy_o <= 1'b1;
            state  <= S_ROT;
          end
        end
        S_ROT: begin
          x_r  <= x_nx;
          y_r  <= y_nx;
          z_r  <= z_nx;
          iter <= iter + 5'd1;
          if (iter == LAST_ITER) state <= S_SCALE;
        end
        S_SCALE: begin
          x_o    <= sat(x_scl);
          y_o    <= sat(y_scl);
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_cordic_circ_rot_mode.sv
// Directed bench for cordic_circ_rot_mode: stimulus pushes hand-computed
// results into a queue, a negedge monitor checks done/busy timing and values.
module tb_cordic_circ_rot_mode;
  localparam int W   = 18;
  localparam int LAT = 17;
  localparam int TOL = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] x_in = '0, y_in = '0, th_in = '0;
  logic         busy, done;
  logic [W-1:0] x_out, y_out;
  logic [1:0]   state_dbg;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_count = 0;

  logic [2*W-1:0] exp_q[$];
  int             samp_q[$];
  int             done_q[$];

  cordic_circ_rot_mode dut (
    .sys_clk_i (clk),
    .reset_i   (reset),
    .start_i   (start),
    .x_i       (x_in),
    .y_i       (y_in),
    .theta_i   (th_in),
    .busy_o    (busy),
    .done_o    (done),
    .x_o       (x_out),
    .y_o       (y_out),
    .state_o   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp, input int tol);
    int d;
    checks++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
    end
  endtask

  function automatic int tol_for(input int v);
    return (v == 131071 || v == -131072) ? 0 : TOL;
  endfunction

  task automatic flush();
    exp_q.delete();
    samp_q.delete();
    done_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input int x, input int y, input int th, input int ex, input int ey);
    @(negedge clk);
    x_in  = W'(x);
    y_in  = W'(y);
    th_in = W'(th);
    start = 1'b1;
    exp_q.push_back({W'(ex), W'(ey)});
    samp_q.push_back(cyc + 1);
    done_q.push_back(cyc + 1 + LAT);
    @(negedge clk);
    start = 1'b0;
    x_in  = W'($urandom_range(0, 262143));
    y_in  = W'($urandom_range(0, 262143));
    th_in = W'($urandom_range(0, 262143));
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending results required 0 after %0d cycles",
               exp_q.size(), budget);
      flush();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic           eb, ed;
    logic [2*W-1:0] e;
    int             ex, ey;
    if (!reset) begin
      eb = (done_q.size() > 0) && (samp_q[0] <= cyc) && (cyc < done_q[0]);
      ed = (done_q.size() > 0) && (cyc == done_q[0]);
      check("busy", int'(busy), int'(eb), 0);
      check("done", int'(done), int'(ed), 0);
      if (done) done_count++;
      if (ed) begin
        e  = exp_q.pop_front();
        void'(samp_q.pop_front());
        void'(done_q.pop_front());
        ex = int'($signed(e[2*W-1:W]));
        ey = int'($signed(e[W-1:0]));
        if (done) begin
          check("x_out", int'($signed(x_out)), ex, tol_for(ex));
          check("y_out", int'($signed(y_out)), ey, tol_for(ey));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int vx[4] = '{100000, 0, 100000, -100000};
  int vy[4] = '{0, 50000, 0, 0};
  int vt[4] = '{0, 0, -65536, 0};
  int rx[4] = '{100000, 0, 0, -100000};
  int ry[4] = '{0, 50000, -100000, 0};

  initial begin
    int dc0;
    repeat (3) @(negedge clk);
    check("rst_x", int'($signed(x_out)), 0, 0);
    check("rst_y", int'($signed(y_out)), 0, 0);
    check("rst_busy", int'(busy), 0, 0);
    check("rst_done", int'(done), 0, 0);
    check("rst_state", int'(state_dbg), 0, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // zero angle, then output hold
    issue(100000, 0, 0, 100000, 0);
    wait_drain(40);
    repeat (3) @(negedge clk);
    check("hold_x", int'($signed(x_out)), 100000, TOL);
    check("hold_y", int'($signed(y_out)), 0, TOL);

    // +90 (boundary, no pre-rotation) and -180 (pre-rotation, negated full scale)
    issue(100000, 0, 65536, 0, 100000);
    wait_drain(40);
    issue(100000, 0, -131072, -100000, 0);
    wait_drain(40);

    // 45 deg and -135 deg
    issue(100000, 0, 32768, 70711, 70711);
    wait_drain(40);
    issue(100000, 0, -98304, -70711, -70711);
    wait_drain(40);

    // 135 deg pre-rotation on the positive side
    issue(100000, 0, 98304, -70711, 70711);
    wait_drain(40);

    // saturation of y
    issue(131071, 131071, 32768, 0, 131071);
    wait_drain(40);

    // start held high with inputs changing every cycle
    dc0 = done_count;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      x_in  = W'(vx[k % 4]);
      y_in  = W'(vy[k % 4]);
      th_in = W'(vt[k % 4]);
      start = 1'b1;
      if (k % 18 == 0) begin
        exp_q.push_back({W'(rx[k % 4]), W'(ry[k % 4])});
        samp_q.push_back(cyc + 1);
        done_q.push_back(cyc + 1 + LAT);
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("held_start_dones", done_count - dc0, 2, 0);
    wait_drain(40);

    // reset mid-operation aborts
    issue(-100000, 0, 65536, 0, -100000);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    flush();
    @(negedge clk);
    check("abort_x", int'($signed(x_out)), 0, 0);
    check("abort_y", int'($signed(y_out)), 0, 0);
    check("abort_busy", int'(busy), 0, 0);
    check("abort_done", int'(done), 0, 0);
    check("abort_state", int'(state_dbg), 0, 0);
    reset = 1'b0;
    repeat (25) @(negedge clk);

    // fresh start after abort
    issue(100000, 0, 32768, 70711, 70711);
    wait_drain(40);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
